nn_layer_chain_seq: RTL

- Parametrised N-layer fully-connected network engine, successor to the fixed three-layer chained-layer top.
- One time-multiplexed MAC evaluates all layers in sequence; activations ping-pong between two internal buffers.
- Weights and biases arrive as a ready/valid stream from the parameter memory, not as flat buses.
- Input vector streams in, output vector streams out, and a done pulse is produced. It sits between the sample loader and the classifier readout.

---
 rtl/nn_seq_pkg.sv | 67 ++++++
 rtl/nn_mac_unit.sv | 58 +++++
 rtl/nn_layer_chain_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/nn_seq_pkg.sv
// Shared types, width derivations and fixed-point helpers for the
// sequential N-layer fully-connected engine.
package nn_seq_pkg;

    localparam int unsigned MAX_LAYERS = 8;
    localparam int unsigned SIZES_W    = (MAX_LAYERS + 1) * 8;
    localparam int unsigned SAT_W      = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IN,
        S_BIAS,
        S_MAC,
        S_WRITE,
        S_DRAIN
    } state_t;

    // Accumulator wide enough for MAX_WIDTH full-width products plus a bias.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned max_width);
        return 2 * data_w + $clog2(max_width) + 1;
    endfunction

    // Counter width able to hold the value max_width itself.
    function automatic int unsigned cnt_width(input int unsigned max_width);
        return $clog2(max_width + 1);
    endfunction

    // Buffer index width.
    function automatic int unsigned idx_width(input int unsigned max_width);
        return (max_width > 1) ? $clog2(max_width) : 1;
    endfunction

    // Field i of the packed layer-size vector (field 0 = input size).
    function automatic logic [7:0] layer_size(input logic [SIZES_W-1:0] sizes,
                                              input int unsigned i);
        return 8'(sizes >> (i * 8));
    endfunction

    // Clip a wide signed value to the signed range of dw bits.
    function automatic logic signed [SAT_W-1:0] saturate(input  logic signed [SAT_W-1:0] v,
                                                         input  int unsigned dw,
                                                         output logic clipped);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        clipped = 1'b0;
        r = v;
        if (v > hi) begin
            r = hi;
            clipped = 1'b1;
        end else if (v < lo) begin
            r = lo;
            clipped = 1'b1;
        end
        return r;
    endfunction

    // Rectified linear: negative values become zero when enabled.
    function automatic logic signed [SAT_W-1:0] relu(input logic signed [SAT_W-1:0] v,
                                                     input logic en);
        return (en && v[SAT_W-1]) ? '0 : v;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Single time-shared multiply-accumulate unit with bias load, floor
// rescale, saturation and optional ReLU on the result path.
module nn_mac_unit
    import nn_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_bias,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic              relu_en,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [SAT_W-1:0]    wide;
    logic signed [SAT_W-1:0]    clipped_v;
    logic signed [SAT_W-1:0]    act;
    logic                       clip;

    // Full-width product, bias aligned to the product's binary point.
    always_comb begin
        prod     = $signed(x) * $signed(w);
        bias_ext = ACC_W'($signed(w)) <<< FRAC_W;
    end

    // Accumulator register: bias load starts a neuron, each weight adds a product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= bias_ext;
        end else if (accumulate) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // Floor rescale, saturate to DATA_W, then optional ReLU.
    always_comb begin
        clip      = 1'b0;
        shifted   = acc >>> FRAC_W;
        wide      = SAT_W'(shifted);
        clipped_v = saturate(wide, DATA_W, clip);
        act       = relu(clipped_v, relu_en);
        result    = DATA_W'(act);
        sat       = clip;
    end

endmodule

// File: rtl/nn_layer_chain_seq.sv
// Sequential N-layer fully-connected engine: one MAC evaluates every
// neuron in turn, activations ping-pong between two register buffers,
// parameters arrive as a bias-then-weights ready/valid stream.
module nn_layer_chain_seq
    import nn_seq_pkg::*;
#(
    parameter int unsigned                    DATA_W      = 16,
    parameter int unsigned                    FRAC_W      = 8,
    parameter int unsigned                    NUM_LAYERS  = 3,
    parameter int unsigned                    MAX_WIDTH   = 128,
    parameter logic [(NUM_LAYERS+1)*8-1:0]    LAYER_SIZES = {8'd10, 8'd64, 8'd128, 8'd128},
    parameter logic [NUM_LAYERS-1:0]          RELU_MASK   = 3'b011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              param_valid,
    output logic              param_ready,
    input  logic [DATA_W-1:0] param_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    localparam int unsigned ACC_W = acc_width(DATA_W, MAX_WIDTH);
    localparam int unsigned CNT_W = cnt_width(MAX_WIDTH);
    localparam int unsigned IDX_W = idx_width(MAX_WIDTH);
    localparam logic [SIZES_W-1:0] SIZES_EXT = SIZES_W'(LAYER_SIZES);
    localparam logic [7:0]         RELU_EXT  = 8'(RELU_MASK);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  neuron;
    logic [3:0]        layer;
    logic              src_sel;

    logic [DATA_W-1:0] buf_a [MAX_WIDTH];
    logic [DATA_W-1:0] buf_b [MAX_WIDTH];

    logic [7:0]        size0;
    logic [7:0]        size_in;
    logic [7:0]        size_out;
    logic [7:0]        size_final;
    logic              last_in;
    logic              last_k;
    logic              last_neuron;
    logic              last_layer;
    logic              last_out;
    logic              in_hs;
    logic              param_hs;
    logic              out_hs;
    logic              relu_en;
    logic [IDX_W-1:0]  k_idx;
    logic [IDX_W-1:0]  n_idx;
    logic [DATA_W-1:0] x_sel;
    logic [DATA_W-1:0] result_buf;
    logic [DATA_W-1:0] mac_result;
    logic              mac_sat;

    // Layer geometry and loop-termination flags for the current position.
    always_comb begin
        size0       = layer_size(SIZES_EXT, 0);
        size_in     = layer_size(SIZES_EXT, 32'(layer) - 32'd1);
        size_out    = layer_size(SIZES_EXT, 32'(layer));
        size_final  = layer_size(SIZES_EXT, NUM_LAYERS);
        last_in     = (k == CNT_W'(size0 - 8'd1));
        last_k      = (k == CNT_W'(size_in - 8'd1));
        last_neuron = (neuron == CNT_W'(size_out - 8'd1));
        last_layer  = (layer == 4'(NUM_LAYERS));
        last_out    = (k == CNT_W'(size_final - 8'd1));
        relu_en     = RELU_EXT[3'(layer - 4'd1)];
        in_hs       = in_valid && in_ready;
        param_hs    = param_valid && param_ready;
        out_hs      = out_valid && out_ready;
        k_idx       = IDX_W'(k);
        n_idx       = IDX_W'(neuron);
        // src_sel=0: layer reads A and writes B; the last written buffer feeds the drain.
        x_sel       = src_sel ? buf_b[k_idx] : buf_a[k_idx];
        result_buf  = src_sel ? buf_a[k_idx] : buf_b[k_idx];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (in_hs) state_n = (size0 == 8'd1) ? S_BIAS : S_LOAD_IN;
            S_LOAD_IN: if (in_hs && last_in) state_n = S_BIAS;
            S_BIAS:    if (param_hs) state_n = S_MAC;
            S_MAC:     if (param_hs && last_k) state_n = S_WRITE;
            S_WRITE:   state_n = (last_neuron && last_layer) ? S_DRAIN : S_BIAS;
            S_DRAIN:   if (out_hs && last_out) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Handshake and stream outputs decoded from the current state.
    always_comb begin
        in_ready    = 1'b0;
        param_ready = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
            end
            S_LOAD_IN:     in_ready    = !rst;
            S_BIAS, S_MAC: param_ready = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = result_buf;
                out_last  = last_out;
                done      = out_ready && last_out;
            end
            default: ;
        endcase
    end

    // Counters, layer/neuron sequencing, buffer select and sticky saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            neuron   <= '0;
            layer    <= '0;
            src_sel  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (in_hs) begin
                    sat_flag <= 1'b0;
                    layer    <= 4'd1;
                    neuron   <= '0;
                    src_sel  <= 1'b0;
                    k        <= (size0 == 8'd1) ? '0 : CNT_W'(1);
                end
                S_LOAD_IN: if (in_hs) k <= last_in ? '0 : k + 1'b1;
                S_MAC:     if (param_hs) k <= last_k ? '0 : k + 1'b1;
                S_WRITE: begin
                    if (mac_sat) sat_flag <= 1'b1;
                    if (!last_neuron) begin
                        neuron <= neuron + 1'b1;
                    end else if (!last_layer) begin
                        src_sel <= ~src_sel;
                        layer   <= layer + 4'd1;
                        neuron  <= '0;
                    end
                end
                S_DRAIN: if (out_hs) k <= last_out ? '0 : k + 1'b1;
                default: ;
            endcase
        end
    end

    // Activation buffers: inputs land in A, each layer writes the non-source buffer.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            buf_a[k_idx] <= in_data;
        end else if (state == S_WRITE && src_sel) begin
            buf_a[n_idx] <= mac_result;
        end
        if (state == S_WRITE && !src_sel) begin
            buf_b[n_idx] <= mac_result;
        end
    end

    nn_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .load_bias  (state == S_BIAS && param_hs),
        .accumulate (state == S_MAC && param_hs),
        .x          (x_sel),
        .w          (param_data),
        .relu_en    (relu_en),
        .result     (mac_result),
        .sat        (mac_sat)
    );

endmodule
